// File: rtl/fountaincoder_driver.sv
// Sequences an external fountain-coder engine: reset, opcode setup, entry load, run-until-stable.
// Optional macro DRIVER_TIMEOUT_EN adds a RUN-phase cycle budget (RUN_MAX) ending in a timeout result.
module fountaincoder_driver #(
  parameter int unsigned STABLE_CYCLES = 3,
  parameter int unsigned RUN_MAX       = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_len,
  input  logic        ent_valid,
  output logic        ent_ready,
  input  logic [3:0]  ent_index,
  input  logic [3:0]  ent_data,
  output logic        core_rst_n,
  output logic [1:0]  core_insn,
  output logic [3:0]  core_index,
  output logic [3:0]  core_data,
  output logic        core_load,
  output logic        core_run,
  input  logic [12:0] core_out,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [12:0] res_data,
  output logic        res_timeout
);

  // Stability counter never stores STABLE_CYCLES itself: reaching it ends the run.
  localparam int unsigned StW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

  typedef enum logic [2:0] {StIdle, StCrst, StInit, StLoad, StRun, StResult} state_e;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [4:0]  len_q, len_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        load_q, load_d;
  logic [3:0]  index_q, index_d;
  logic [3:0]  data_q, data_d;
  logic [12:0] prev_q, prev_d;
  logic [StW-1:0] stable_q, stable_d;
  logic        first_q, first_d;
  logic [12:0] res_data_q, res_data_d;
  logic        res_to_q, res_to_d;

  logic        cmd_ready_c, ent_ready_c, core_run_c, core_rst_n_c, res_valid_c;
  logic [1:0]  insn_c;

`ifdef DRIVER_TIMEOUT_EN
  localparam int unsigned RcW = (RUN_MAX > 1) ? $clog2(RUN_MAX) : 1;
  logic [RcW-1:0] run_cnt_q, run_cnt_d;
`else
  logic unused_run_max;
  assign unused_run_max = ^RUN_MAX;
`endif

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    load_d       = 1'b0;
    index_d      = index_q;
    data_d       = data_q;
    prev_d       = prev_q;
    stable_d     = '0;
    first_d      = (state_q != StRun);
    res_data_d   = res_data_q;
    res_to_d     = res_to_q;
    cmd_ready_c  = 1'b0;
    ent_ready_c  = 1'b0;
    core_run_c   = 1'b0;
    core_rst_n_c = 1'b1;
    res_valid_c  = 1'b0;
    insn_c       = 2'b00;
`ifdef DRIVER_TIMEOUT_EN
    run_cnt_d    = '0;
`endif

    unique case (state_q)
      StIdle: begin
        cmd_ready_c = 1'b1;
        if (cmd_valid) begin
          op_d  = cmd_op;
          len_d = (cmd_len > 5'd16) ? 5'd16 : cmd_len;
          cnt_d = '0;
          if (cmd_op == 2'b11) begin
            // Reserved opcode: answer immediately without touching the engine.
            res_data_d = '0;
            res_to_d   = 1'b1;
            state_d    = StResult;
          end else begin
            state_d = StCrst;
          end
        end
      end
      StCrst: begin
        core_rst_n_c = 1'b0;
        state_d      = StInit;
      end
      StInit: begin
        insn_c  = op_q;
        state_d = (len_q == 5'd0) ? StRun : StLoad;
      end
      StLoad: begin
        insn_c = op_q;
        if (cnt_q == len_q) begin
          // Final strobe is on the bus this cycle; start running next.
          state_d = StRun;
        end else begin
          ent_ready_c = 1'b1;
          if (ent_valid) begin
            load_d  = 1'b1;
            index_d = ent_index;
            data_d  = ent_data;
            cnt_d   = cnt_q + 5'd1;
          end
        end
      end
      StRun: begin
        insn_c     = op_q;
        core_run_c = 1'b1;
        prev_d     = core_out;
        if (!first_q && (core_out == prev_q)) begin
          if ((32'(stable_q) + 32'd1) >= STABLE_CYCLES) begin
            res_data_d = core_out;
            res_to_d   = 1'b0;
            state_d    = StResult;
          end else begin
            stable_d = stable_q + StW'(1);
          end
        end
`ifdef DRIVER_TIMEOUT_EN
        if (state_d == StRun) begin
          if ((32'(run_cnt_q) + 32'd1) >= RUN_MAX) begin
            res_data_d = core_out;
            res_to_d   = 1'b1;
            state_d    = StResult;
          end else begin
            run_cnt_d = run_cnt_q + RcW'(1);
          end
        end
`endif
      end
      StResult: begin
        res_valid_c = 1'b1;
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      op_q       <= 2'b00;
      len_q      <= '0;
      cnt_q      <= '0;
      load_q     <= 1'b0;
      index_q    <= '0;
      data_q     <= '0;
      prev_q     <= '0;
      stable_q   <= '0;
      first_q    <= 1'b1;
      res_data_q <= '0;
      res_to_q   <= 1'b0;
`ifdef DRIVER_TIMEOUT_EN
      run_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      load_q     <= load_d;
      index_q    <= index_d;
      data_q     <= data_d;
      prev_q     <= prev_d;
      stable_q   <= stable_d;
      first_q    <= first_d;
      res_data_q <= res_data_d;
      res_to_q   <= res_to_d;
`ifdef DRIVER_TIMEOUT_EN
      run_cnt_q  <= run_cnt_d;
`endif
    end
  end

  // Outputs are forced to their reset values for the whole time rst is high.
  assign cmd_ready   = cmd_ready_c & ~rst;
  assign ent_ready   = ent_ready_c & ~rst;
  assign core_rst_n  = core_rst_n_c & ~rst;
  assign core_insn   = rst ? 2'b00 : insn_c;
  assign core_index  = rst ? 4'd0 : index_q;
  assign core_data   = rst ? 4'd0 : data_q;
  assign core_load   = load_q & ~rst;
  assign core_run    = core_run_c & ~rst;
  assign res_valid   = res_valid_c & ~rst;
  assign res_data    = rst ? 13'd0 : res_data_q;
  assign res_timeout = res_to_q & ~rst;

endmodule

// File: tb/tb_fountaincoder_driver.sv
// Self-checking bench for fountaincoder_driver: vector table plus scoreboard, with hand-written
// reset-abort and run-budget sequences.
module tb_fountaincoder_driver;
  localparam int unsigned StableCycles = 3;
  localparam int unsigned RunMax       = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_len;
  logic        ent_valid, ent_ready;
  logic [3:0]  ent_index, ent_data;
  logic        core_rst_n, core_load, core_run;
  logic [1:0]  core_insn;
  logic [3:0]  core_index, core_data;
  logic [12:0] core_out;
  logic        res_valid, res_ready, res_timeout;
  logic [12:0] res_data;

  always #5 clk = ~clk;

  fountaincoder_driver #(
    .STABLE_CYCLES(StableCycles),
    .RUN_MAX      (RunMax)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_len    (cmd_len),
    .ent_valid  (ent_valid),
    .ent_ready  (ent_ready),
    .ent_index  (ent_index),
    .ent_data   (ent_data),
    .core_rst_n (core_rst_n),
    .core_insn  (core_insn),
    .core_index (core_index),
    .core_data  (core_data),
    .core_load  (core_load),
    .core_run   (core_run),
    .core_out   (core_out),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_timeout(res_timeout)
  );

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  len;
    int          gap;
    int          hold;
    logic [3:0]  idx_base;
    logic [3:0]  dat_base;
    logic [12:0] stub;
  } vec_t;

  typedef struct {
    logic [12:0] data;
    logic        to;
  } exp_t;

  int checks   = 0;
  int failures = 0;

  exp_t        sb[$];
  logic [7:0]  load_log[$];
  int          run_count  = 0;
  int          crst_count = 0;
  logic [1:0]  run_insn   = 2'b00;
  logic [12:0] last_run_out = '0;
  int          stub_mode  = 0;
  logic [12:0] stub_val   = '0;

  // Engine stub drives core_out; the same process logs strobes seen on the engine side.
  always @(negedge clk) begin
    if (stub_mode == 1) core_out = (core_out == 13'h0AAA) ? 13'h1555 : 13'h0AAA;
    else                core_out = stub_val;
    if (core_load) load_log.push_back({core_index, core_data});
    if (core_run) begin
      run_count++;
      run_insn     = core_insn;
      last_run_out = core_out;
    end
    if (!core_rst_n && !rst) crst_count++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic wait_cmd_ready();
    int guard = 0;
    while (!cmd_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("cmd_ready_idle", cmd_ready, 1);
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [4:0] len);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic send_entry(input logic [3:0] idx, input logic [3:0] dat);
    int guard = 0;
    ent_valid = 1'b1;
    ent_index = idx;
    ent_data  = dat;
    while (!ent_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int   n_ent, lpos, rbase, cbase, guard, exp_runs;
    exp_t e;
    logic ok;
    logic [7:0] exp_ld;
    n_ent    = (v.op == 2'b11) ? 0 : ((v.len > 5'd16) ? 16 : int'(v.len));
    exp_runs = (v.op == 2'b11) ? 0 : int'(StableCycles) + 1;
    stub_mode = 0;
    stub_val  = v.stub;
    @(negedge clk);
    lpos  = load_log.size();
    rbase = run_count;
    cbase = crst_count;
    wait_cmd_ready();
    e.data = (v.op == 2'b11) ? 13'd0 : v.stub;
    e.to   = (v.op == 2'b11);
    sb.push_back(e);
    send_cmd(v.op, v.len);
    for (int k = 0; k < n_ent; k++) begin
      ent_valid = 1'b0;
      repeat (v.gap) @(negedge clk);
      send_entry(v.idx_base + 4'(k), v.dat_base + 4'(k));
    end
    ent_valid = 1'b0;
    if (n_ent > 0) check($sformatf("v%0d_after_last_ready_load", id), {ent_ready, core_load}, 2'b01);
    guard = 0;
    while (!res_valid && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check($sformatf("v%0d_res_valid", id), res_valid, 1);
    e = sb.pop_front();
    check($sformatf("v%0d_res_data", id), res_data, e.data);
    check($sformatf("v%0d_res_timeout", id), res_timeout, e.to);
    check($sformatf("v%0d_cmd_ready_in_result", id), cmd_ready, 0);
    if (v.hold > 0) begin
      ok = 1'b1;
      for (int h = 0; h < v.hold; h++) begin
        @(negedge clk);
        ok &= (res_valid === 1'b1) && (res_data === e.data) && (res_timeout === e.to) &&
              (cmd_ready === 1'b0);
      end
      check($sformatf("v%0d_hold_stable", id), ok, 1);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check($sformatf("v%0d_cmd_ready_after_hs", id), cmd_ready, 1);
    check($sformatf("v%0d_res_valid_after_hs", id), res_valid, 0);
    check($sformatf("v%0d_load_count", id), load_log.size() - lpos, n_ent);
    ok = 1'b1;
    for (int j = 0; j < n_ent && (lpos + j) < load_log.size(); j++) begin
      exp_ld = {v.idx_base + 4'(j), v.dat_base + 4'(j)};
      ok &= (load_log[lpos + j] === exp_ld);
    end
    check($sformatf("v%0d_load_content", id), ok, 1);
    check($sformatf("v%0d_run_cycles", id), run_count - rbase, exp_runs);
    check($sformatf("v%0d_crst_cycles", id), crst_count - cbase, (v.op == 2'b11) ? 0 : 1);
    if (v.op != 2'b11) check($sformatf("v%0d_run_insn", id), run_insn, v.op);
  endtask

  vec_t vecs[6];

  initial begin
    logic any_res;
    int   rbase, guard;
    vecs[0] = '{op: 2'd0, len: 5'd1,  gap: 0, hold: 0,  idx_base: 4'd5, dat_base: 4'd0,  stub: 13'h0005};
    vecs[1] = '{op: 2'd2, len: 5'd3,  gap: 1, hold: 0,  idx_base: 4'd2, dat_base: 4'd9,  stub: 13'h0123};
    vecs[2] = '{op: 2'd1, len: 5'd0,  gap: 0, hold: 10, idx_base: 4'd0, dat_base: 4'd0,  stub: 13'h1FFF};
    vecs[3] = '{op: 2'd0, len: 5'd20, gap: 0, hold: 0,  idx_base: 4'd0, dat_base: 4'd3,  stub: 13'h0007};
    vecs[4] = '{op: 2'd3, len: 5'd5,  gap: 0, hold: 0,  idx_base: 4'd0, dat_base: 4'd0,  stub: 13'h00AB};
    vecs[5] = '{op: 2'd1, len: 5'd16, gap: 2, hold: 2,  idx_base: 4'd1, dat_base: 4'd14, stub: 13'h0ABC};

    rst = 1'b1;
    cmd_valid = 1'b1;
    cmd_op = 2'b01;
    cmd_len = 5'd2;
    ent_valid = 1'b1;
    ent_index = '0;
    ent_data = '0;
    res_ready = 1'b1;
    core_out = '0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_ent_ready", ent_ready, 0);
    check("rst_core_rst_n", core_rst_n, 0);
    check("rst_core_strobes", {core_load, core_run}, 2'b00);
    check("rst_core_bus", {core_insn, core_index, core_data}, 10'd0);
    check("rst_res", {res_valid, res_timeout, res_data}, 15'd0);
    cmd_valid = 1'b0;
    ent_valid = 1'b0;
    res_ready = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", cmd_ready, 1);
    check("post_rst_core_rst_n", core_rst_n, 1);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Abort mid-load: two of four entries, then reset.
    stub_val = 13'h0042;
    wait_cmd_ready();
    send_cmd(2'd2, 5'd4);
    send_entry(4'd3, 4'd4);
    send_entry(4'd4, 4'd5);
    ent_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("abort_core_rst_n", core_rst_n, 0);
    check("abort_ent_ready", ent_ready, 0);
    rst = 1'b0;
    any_res = 1'b0;
    repeat (20) begin
      @(negedge clk);
      any_res |= res_valid;
    end
    check("abort_no_result", any_res, 0);
    check("abort_idle_ready", cmd_ready, 1);
    check("abort_sb_empty", sb.size(), 0);
    run_vec('{op: 2'd2, len: 5'd4, gap: 0, hold: 0, idx_base: 4'd8, dat_base: 4'd2,
              stub: 13'h0FED}, 6);

    // Engine never settles: alternating core_out.
    stub_mode = 1;
    @(negedge clk);
    rbase = run_count;
    wait_cmd_ready();
    send_cmd(2'd0, 5'd0);
`ifdef DRIVER_TIMEOUT_EN
    guard = 0;
    while (!res_valid && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("to_res_valid", res_valid, 1);
    check("to_run_cycles", run_count - rbase, RunMax);
    check("to_res_timeout", res_timeout, 1);
    check("to_res_data", res_data, last_run_out);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("to_cmd_ready_after_hs", cmd_ready, 1);
`else
    guard = 0;
    repeat (100) @(negedge clk);
    check("noto_still_running", core_run, 1);
    check("noto_no_result", res_valid, 0);
    check("noto_run_cycles_min", (run_count - rbase) >= 95, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("noto_idle_after_rst", cmd_ready, 1);
`endif
    stub_mode = 0;
    check("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fountaincoder_driver.md
FOUNTAINCODER_DRIVER -- requirements
Module: fountaincoder_driver

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 3: consecutive unchanged core_out samples that end a run.
REQ-002 SHALL have parameter RUN_MAX, default 40: run-cycle budget before timeout (see REQ-030).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when both high
cmd_op  in  2  00 MIN, 01 MAX, 10 MADD, 11 reserved
cmd_len  in  5  entries to load, 0..16
ent_valid  in  1  entry offered
ent_ready  out  1  entry accepted when both high
ent_index  in  4  entry index
ent_data  in  4  entry data
core_rst_n  out  1  active-low reset to engine
core_insn  out  2  engine opcode
core_index  out  4  engine load index
core_data  out  4  engine load data
core_load  out  1  engine load strobe
core_run  out  1  engine run strobe
core_out  in  13  engine result
res_valid  out  1  result offered
res_ready  in  1  result taken when both high
res_data  out  13  captured core_out
res_timeout  out  1  result ended by budget, not stability

Function
REQ-005 SHALL implement states IDLE, CRST, INIT, LOAD, RUN, RESULT.
REQ-006 IDLE: cmd_ready=1, all core strobes 0, core_rst_n=1; on cmd handshake latch cmd_op/cmd_len, go CRST.
REQ-007 cmd_op=11 SHALL be accepted and return RESULT next cycle with res_data=0, res_timeout=1, engine untouched.
REQ-008 CRST: exactly 1 cycle, core_rst_n=0; then INIT.
REQ-009 INIT: exactly 1 cycle, core_insn=latched op, core_load=0, core_run=0; then LOAD, or RUN if cmd_len=0.
REQ-010 core_insn SHALL hold the latched op from INIT through RUN.
REQ-011 LOAD: ent_ready=1; each handshake drives core_index/core_data registered and core_load=1 on the following cycle, no gaps added by the driver.
REQ-012 Cycles without handshake in LOAD SHALL drive core_load=0 (engine re-initialises; allowed).
REQ-013 LOAD SHALL end after cmd_len handshakes; final strobe issued, then RUN next cycle.
REQ-014 ent_ready SHALL be 0 outside LOAD and in the cycle after the last accepted entry.
REQ-015 cmd_len values 17..31 SHALL saturate to 16.
REQ-016 RUN: core_run=1 every cycle; sample core_out each cycle into prev register.
REQ-017 Stability counter SHALL increment when core_out equals prev, clear otherwise; first RUN cycle counts as a change.
REQ-018 When counter reaches STABLE_CYCLES, capture core_out into res_data, res_timeout=0, deassert core_run, go RESULT.
REQ-019 RESULT: res_valid=1, res_data/res_timeout stable until res_ready; then IDLE.
REQ-020 cmd_ready SHALL be 0 in RESULT; a new command is accepted no earlier than the cycle after the result handshake.
REQ-021 ent_valid outside LOAD and res_ready outside RESULT SHALL be ignored.

Reset
REQ-022 While rst=1: state IDLE, core_rst_n=0, core_load=0, core_run=0, core_insn=00, core_index=0, core_data=0.
REQ-023 While rst=1: cmd_ready=0, ent_ready=0, res_valid=0, res_data=0, res_timeout=0, counters 0.
REQ-024 rst asserted in any state SHALL abort the operation; no result is produced for it.
REQ-025 First cycle after rst deasserts SHALL be IDLE with cmd_ready=1.

Configuration
REQ-030 With DRIVER_TIMEOUT_EN defined: RUN cycle counter; after RUN_MAX RUN cycles without stability capture core_out, res_timeout=1, go RESULT.
REQ-031 Without DRIVER_TIMEOUT_EN: no cycle counter, RUN waits indefinitely for stability, res_timeout=1 only for REQ-007.

Verification
REQ-040 MIN, cmd_len=1, entry (5,0), engine stub core_out=5 from RUN cycle 1 -> res_data=0x0005, res_timeout=0, res_valid at RUN cycle 4.
REQ-041 MADD, cmd_len=3, ent_valid gapped every other cycle -> exactly 3 core_load pulses, correct index/data, RUN starts after 3rd.
REQ-042 core_out toggling each cycle, DRIVER_TIMEOUT_EN defined -> RESULT after 40 RUN cycles, res_timeout=1; undefined -> stays in RUN.
REQ-043 cmd_len=0 -> CRST, INIT, RUN with zero core_load pulses; cmd_len=20 -> 16 entries accepted.
REQ-044 rst pulsed in LOAD after 2 of 4 entries -> IDLE, no res_valid, next command runs full sequence.
REQ-045 res_ready held low 10 cycles -> res_valid/res_data stable, cmd_ready=0 throughout; cmd_ready=1 cycle after handshake.
